// File: rtl/sprite_motion.sv
// rtl/sprite_motion.sv - per-frame sprite centre position engine
//
// Purpose: on each rising edge of frame_clk, samples the keycode and moves the
// sprite centre. Horizontal motion is a clamped constant step. Vertical motion
// is either a GROUND/RISE/FALL jump-and-gravity machine (MOTION_GRAVITY_EN
// defined) or a clamped constant step driven by W/S (MOTION_GRAVITY_EN undefined).
//
// Ports:
//   Clk        in   1   system clock
//   Reset_n    in   1   asynchronous active-low reset
//   frame_clk  in   1   frame strobe, synchronous to Clk; rising edge is used
//   keycode    in   8   USB HID keycode (0x04 A, 0x07 D, 0x1A W, 0x16 S)
//   BallX      out  10  sprite centre column
//   BallY      out  10  sprite centre row
//   Ball_size  out  10  sprite half-width (constant SIZE)
module sprite_motion #(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int X_START  = 320,
  parameter int Y_START  = 240,
  parameter int SIZE     = 4,
  parameter int STEP     = 2,
  parameter int JUMP_VEL = 10,
  parameter int VMAX     = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  localparam logic signed [10:0] SIZE_S = 11'(SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);

  // Move pos by delta, then keep the whole sprite inside [lo, hi].
  function automatic logic [9:0] clamp_step(input logic [9:0]        pos,
                                            input logic signed [10:0] delta,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
    logic signed [10:0] cand;
    cand = $signed({1'b0, pos}) + delta;
    if (cand - SIZE_S < lo)
      return 10'(lo + SIZE_S);
    else if (cand + SIZE_S > hi)
      return 10'(hi - SIZE_S);
    else
      return cand[9:0];
  endfunction

  logic               frame_clk_q;
  logic               tick;
  logic signed [10:0] dx;
  logic [9:0]         x_next;
  logic [9:0]         y_next;

  assign tick      = frame_clk & ~frame_clk_q;
  assign Ball_size = 10'(SIZE);

  always_comb begin
    dx = '0;
    if (keycode == KEY_LEFT)
      dx = -STEP_S;
    else if (keycode == KEY_RIGHT)
      dx = STEP_S;
    x_next = clamp_step(BallX, dx, XMIN_S, XMAX_S);
  end

`ifdef MOTION_GRAVITY_EN
  localparam logic [9:0] FLOOR   = 10'(Y_MAX - SIZE);
  localparam logic [9:0] CEIL    = 10'(Y_MIN + SIZE);
  localparam logic [4:0] VEL_JMP = 5'(JUMP_VEL);
  localparam logic [4:0] VEL_MAX = 5'(VMAX);

  typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_FALL} state_t;

  state_t     state, state_next;
  logic [4:0] vel, vel_next;

  always_comb begin
    state_next = state;
    vel_next   = vel;
    y_next     = BallY;
    case (state)
      ST_GROUND: begin
        y_next = FLOOR;
        // The jump starts next tick; position is unchanged on the take-off tick.
        if (keycode == KEY_UP) begin
          state_next = ST_RISE;
          vel_next   = VEL_JMP;
        end
      end
      ST_RISE: begin
        y_next   = BallY - {5'b0, vel};
        vel_next = vel - 5'd1;
        if (vel_next == 5'd0)
          state_next = ST_FALL;
        // Look ahead: if the next rise step would cross the ceiling, pin there now.
        if ({1'b0, y_next} < 11'(CEIL) + {6'b0, vel_next}) begin
          y_next     = CEIL;
          vel_next   = 5'd0;
          state_next = ST_FALL;
        end
      end
      ST_FALL: begin
        y_next   = BallY + {5'b0, vel};
        vel_next = (vel >= VEL_MAX) ? VEL_MAX : vel + 5'd1;
        // Look ahead: land as soon as the next fall step would reach the floor.
        if ({1'b0, y_next} + {6'b0, vel_next} >= {1'b0, FLOOR}) begin
          y_next     = FLOOR;
          vel_next   = 5'd0;
          state_next = ST_GROUND;
        end
      end
      default: begin
        state_next = ST_FALL;
        vel_next   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_FALL;
      vel   <= 5'd0;
    end else if (tick) begin
      state <= state_next;
      vel   <= vel_next;
    end
  end
`else
  localparam logic [7:0]         KEY_DOWN = 8'h16;
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);

  logic signed [10:0] dy;

  always_comb begin
    dy = '0;
    if (keycode == KEY_UP)
      dy = -STEP_S;
    else if (keycode == KEY_DOWN)
      dy = STEP_S;
    y_next = clamp_step(BallY, dy, YMIN_S, YMAX_S);
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q <= 1'b0;
      BallX       <= 10'(X_START);
      BallY       <= 10'(Y_START);
    end else begin
      frame_clk_q <= frame_clk;
      if (tick) begin
        BallX <= x_next;
        BallY <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion.sv
// tb/tb_sprite_motion.sv - self-checking bench for sprite_motion
module tb_sprite_motion;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] BallX, BallY, Ball_size;

  int n_checks = 0;
  int n_errors = 0;

  sprite_motion dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .BallX     (BallX),
    .BallY     (BallY),
    .Ball_size (Ball_size)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: sprite centre plus, in gravity mode, speed and phase.
  int m_x, m_y, m_vel, m_phase;   // phase 0 ground, 1 rising, 2 falling

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    m_x = 320; m_y = 240; m_vel = 0; m_phase = 2;
  endfunction

  function automatic void model_tick(logic [7:0] k);
    int dx;
    dx = (k == 8'h04) ? -2 : (k == 8'h07) ? 2 : 0;
    m_x = clampi(m_x + dx, 4, 635);
`ifdef MOTION_GRAVITY_EN
    if (m_phase == 0) begin
      m_y = 475;
      if (k == 8'h1A) begin m_phase = 1; m_vel = 10; end
    end else if (m_phase == 1) begin
      m_y = m_y - m_vel;
      m_vel = m_vel - 1;
      if (m_vel == 0) m_phase = 2;
      if (m_y - m_vel < 4) begin m_y = 4; m_vel = 0; m_phase = 2; end
    end else begin
      m_y = m_y + m_vel;
      m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
      if (m_y + m_vel >= 475) begin m_y = 475; m_vel = 0; m_phase = 0; end
    end
`else
    begin
      int dy;
      dy = (k == 8'h1A) ? -2 : (k == 8'h16) ? 2 : 0;
      m_y = clampi(m_y + dy, 4, 475);
    end
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, " x"}, int'(BallX), m_x);
    check({name, " y"}, int'(BallY), m_y);
  endtask

  // One frame: frame_clk high for 'hold' cycles, then low with keycode noise.
  task automatic tick_hold(input logic [7:0] k, input int hold);
    @(negedge Clk);
    keycode   = k;
    frame_clk = 1'b1;
    repeat (hold) @(negedge Clk);
    frame_clk = 1'b0;
    keycode   = 8'($urandom);
    model_tick(k);
    @(negedge Clk);
  endtask

  task automatic tick(input logic [7:0] k);
    tick_hold(k, 1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] key;
    int         ex;
    int         ey;
  } vec_t;

  vec_t tbl[12];
  int   arc[10];

  initial begin
    tbl[0]  = '{8'h07, 322, 240};
    tbl[1]  = '{8'h07, 324, 240};
    tbl[2]  = '{8'h07, 326, 240};
    tbl[3]  = '{8'h07, 328, 240};
    tbl[4]  = '{8'h07, 330, 240};
`ifdef MOTION_GRAVITY_EN
    // Free fall from reset: speed grows by one per frame.
    tbl[0].ey = 240; tbl[1].ey = 241; tbl[2].ey = 243; tbl[3].ey = 246; tbl[4].ey = 250;
    tbl[5]  = '{8'h16, 330, 255};
    tbl[6]  = '{8'h16, 330, 261};
    tbl[7]  = '{8'h16, 330, 268};
    tbl[8]  = '{8'h00, 330, 276};
    tbl[9]  = '{8'h1A, 330, 284};
    tbl[10] = '{8'h04, 328, 292};
    tbl[11] = '{8'h55, 328, 300};
`else
    tbl[5]  = '{8'h16, 330, 242};
    tbl[6]  = '{8'h16, 330, 244};
    tbl[7]  = '{8'h16, 330, 246};
    tbl[8]  = '{8'h00, 330, 246};
    tbl[9]  = '{8'h1A, 330, 244};
    tbl[10] = '{8'h04, 328, 244};
    tbl[11] = '{8'h55, 328, 244};
`endif
    arc = '{465, 456, 448, 441, 435, 430, 426, 423, 421, 420};

    // Reset state
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);
    check("reset BallX", int'(BallX), 320);
    check("reset BallY", int'(BallY), 240);
    check("Ball_size", int'(Ball_size), 4);

    // A long frame_clk high produces a single update
    tick_hold(8'h07, 100);
    check("hold BallX", int'(BallX), 322);
    check_model("hold");

    // Table of frames from reset
    do_reset();
    foreach (tbl[i]) begin
      tick(tbl[i].key);
      check($sformatf("tbl[%0d] x", i), int'(BallX), tbl[i].ex);
      check($sformatf("tbl[%0d] y", i), int'(BallY), tbl[i].ey);
    end

    // Horizontal clamps: right edge, then walk left to 7 and into the left edge
    do_reset();
    repeat (160) tick(8'h07);
    check("right clamp", int'(BallX), 635);
    repeat (314) tick(8'h04);
    check("walk to 7", int'(BallX), 7);
    tick(8'h04); check("left 5", int'(BallX), 5);
    tick(8'h04); check("left clamp a", int'(BallX), 4);
    tick(8'h04); check("left clamp b", int'(BallX), 4);

`ifdef MOTION_GRAVITY_EN
    // Fall from reset, land, jump arc, fall back
    do_reset();
    tick(8'h00); check("fall 1", int'(BallY), 240);
    tick(8'h00); check("fall 2", int'(BallY), 241);
    tick(8'h00); check("fall 3", int'(BallY), 243);
    tick(8'h00); check("fall 4", int'(BallY), 246);
    for (int i = 0; i < 60; i++) tick(8'h00);
    check("landed", int'(BallY), 475);
    tick(8'h00); check("ground hold", int'(BallY), 475);
    tick(8'h1A); check("takeoff", int'(BallY), 475);
    for (int i = 0; i < 10; i++) begin
      tick(8'h00);
      check($sformatf("arc[%0d]", i), int'(BallY), arc[i]);
    end
    for (int i = 0; i < 20; i++) tick(8'h00);
    check("relanded", int'(BallY), 475);
    // Held W re-jumps after every landing
    for (int i = 0; i < 25; i++) begin
      tick(8'h1A);
      check_model("held W");
    end
    // Abandon a jump with async reset at BallY=441
    for (int i = 0; i < 30; i++) tick(8'h00);
    tick(8'h1A);
    repeat (4) tick(8'h07);
    check("pre-reset y", int'(BallY), 441);
`else
    // Vertical clamps
    repeat (130) tick(8'h1A);
    check("ceil clamp", int'(BallY), 4);
    repeat (240) tick(8'h16);
    check("floor clamp", int'(BallY), 475);
    tick(8'h1A);
    check("off floor", int'(BallY), 473);
    repeat (3) tick(8'h07);
    check_model("pre-reset");
`endif

    // Async reset between clock edges
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async BallX", int'(BallX), 320);
    check("async BallY", int'(BallY), 240);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;

    // Random frames against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] k;
      case ($urandom_range(0, 5))
        0: k = 8'h04;
        1: k = 8'h07;
        2: k = 8'h1A;
        3: k = 8'h16;
        4: k = 8'h00;
        default: k = 8'($urandom);
      endcase
      tick_hold(k, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge Clk);
      check_model($sformatf("rand[%0d]", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_motion.md
# sprite_motion

Per-frame motion engine for the player sprite. Once per video frame it reads the current USB keycode and updates the sprite centre position. Horizontal motion is constant-step; vertical motion uses a jump/gravity state machine. It sits directly upstream of the color mapper and drives that block's BallX, BallY and Ball_size inputs.

## Interface
- X_MIN, 0: leftmost legal pixel column.
- X_MAX, 639: rightmost legal pixel column.
- Y_MIN, 0: top legal pixel row.
- Y_MAX, 479: bottom legal pixel row.
- X_START, 320: centre X after reset.
- Y_START, 240: centre Y after reset.
- SIZE, 4: sprite half-width, in pixels.
- STEP, 2: pixels moved per frame for each held direction key.
- JUMP_VEL, 10: initial upward speed, in pixels per frame.
- VMAX, 8: terminal fall speed, in pixels per frame.
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync-derived frame strobe, synchronous to Clk. Only its rising edge is used.
- keycode  in  8  USB HID keycode. Decoded values:
  - 0x04 = A (left)
  - 0x07 = D (right)
  - 0x1A = W (jump/up)
  - 0x16 = S (down)
  - all other values = no key.
- BallX  out  10  sprite centre column.
- BallY  out  10  sprite centre row.
- Ball_size  out  10  constant value SIZE.

## Operation
- Frame tick detection:
  - frame_clk is registered into frame_clk_q.
  - tick = frame_clk & ~frame_clk_q.
  - All position, velocity and state updates happen only on ticks.
  - keycode is sampled only on ticks.
- Horizontal axis:
  - dx = -STEP for 0x04, +STEP for 0x07, 0 otherwise.
  - cand = BallX + dx, computed in 11-bit signed arithmetic.
  - If cand - SIZE < X_MIN, BallX becomes X_MIN+SIZE.
  - Else if cand + SIZE > X_MAX, BallX becomes X_MAX-SIZE.
  - Otherwise BallX becomes cand.
- Vertical axis: FLOOR = Y_MAX-SIZE and CEIL = Y_MIN+SIZE. vel is unsigned 5-bit.
- State GROUND:
  - BallY is held at FLOOR.
  - On keycode 0x1A: go to RISE and set vel=JUMP_VEL. BallY does not change on this tick.
  - W is level-sensitive: holding it re-jumps on the first tick after landing.
- State RISE, on each tick:
  - BallY -= vel, then vel -= 1.
  - If the new vel is 0, go to FALL.
  - If BallY-vel < CEIL: set BallY=CEIL and vel=0, and go to FALL.
- State FALL, on each tick:
  - BallY += vel, then vel = min(vel+1, VMAX).
  - If BallY+vel >= FLOOR: set BallY=FLOOR and vel=0, and go to GROUND.
- Keys A and D act identically in every vertical state.
- Reset values:
  - BallX=X_START, BallY=Y_START
  - state=FALL, vel=0, frame_clk_q=0
  - Ball_size is always SIZE.

## Timing
- BallX and BallY are registered. They change on the Clk edge that samples frame_clk=1 while frame_clk_q=0.
- Latency is therefore one Clk from the frame_clk rise to the new position.
- Exactly one update occurs per frame_clk rising edge, however long frame_clk stays high.
- A keycode change between ticks has no effect until the next tick.
- Reset_n low forces every register to its reset value immediately, without waiting for Clk. Assertion mid-jump abandons the jump.
- The first tick after Reset_n deasserts is processed normally.
- Both axes update on the same tick. The horizontal clamp and the vertical transition are independent.

## Configuration
- MOTION_GRAVITY_EN defined: the GROUND/RISE/FALL machine and vel are built as described above.
- MOTION_GRAVITY_EN undefined:
  - No state machine and no vel register.
  - Keycode 0x1A moves BallY by -STEP and 0x16 by +STEP, clamped to [CEIL, FLOOR] using the same rule as the X axis.
  - Reset position is unchanged.

## Test plan
- Reset and idle:
  - Pulse Reset_n low -> BallX=320, BallY=240, Ball_size=4.
  - Hold frame_clk high for 100 Clk -> exactly one update occurs.
- Horizontal move and clamp:
  - keycode=0x07 for 5 ticks from reset -> BallX=330.
  - Then from BallX=7 with keycode=0x04 -> BallX goes 5, 4, 4.
- Gravity fall:
  - From reset with keycode=0x00 -> BallY after ticks 1..4 = 240, 241, 243, 246.
  - Continue -> BallY lands at 475 and state=GROUND.
- Jump arc:
  - In GROUND, keycode=0x1A for one tick, then 0x00 -> BallY = 465, 456, 448, 441, 435, 430, 426, 423, 421, 420, then falls back to 475.
- Async reset mid-jump:
  - Drop Reset_n between Clk edges at BallY=441 -> BallY=240 and BallX=320 immediately, before the next Clk edge.
- Gravity compiled out (MOTION_GRAVITY_EN undefined):
  - keycode=0x16 for 3 ticks -> BallY=246.
  - Hold 0x1A -> BallY clamps at 4.
